// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package if_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    // One buffered fetch result: the PC it was fetched from and the word returned.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// Synchronous FIFO of {pc, instr} fetch entries with flush; head is read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the producer's credit accounting keeps push from overflowing.
module if_fetch_buffer
    import if_fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          not_empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage, pointers and occupancy; flush beats push/pop, reset also zeroes storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch front end: issues PCs to a 1-cycle imem and buffers tagged responses for ID.
// Latency: PC issued at edge N is at the buffer head after edge N+1; 1 instr/cycle when ID is ready.
// Backpressure: issue stops when buffered + in-flight words would exceed DEPTH; head holds while stalled.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] infl_pc_q;
    logic            infl_q;
    logic            pop;
    logic            issue;
    logic [CW-1:0]   count;
    logic [CW:0]     credits_used;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign imem_addr = pc_q;
    assign pop       = if_valid && id_ready;

    // A slot is reserved for every in-flight read, so the response push can never overflow.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, infl_q} - {{CW{1'b0}}, pop};
    assign issue        = reset && !redirect_valid && (credits_used < DEPTH_C);

    assign push_entry.pc    = infl_pc_q;
    assign push_entry.instr = imem_instr;

    // PC generation and in-flight tracking; redirect discards the read returning next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q   <= {redirect_pc[XLEN-1:2], 2'b00};
            infl_q <= 1'b0;
        end else if (issue) begin
            pc_q      <= pc_q + PC_STEP;
            infl_q    <= 1'b1;
            infl_pc_q <= pc_q;
        end else begin
            infl_q <= 1'b0;
        end
    end

    if_fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (infl_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .not_empty  (if_valid)
    );

    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + PC_STEP;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks = 0;
    int errors = 0;

    // Reference model state: the PC the next consumed instruction must carry.
    logic [31:0] exp_pc = RESET_PC;
    int          since_flush = 3;
    logic        stall_hold = 1'b0;
    logic [31:0] held_pc = '0;
    logic [31:0] held_instr = '0;
    int          n_pops = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    // Memory contents: word at byte address a is {a[26:0], 5'h13}; words 0..3 are 13,93,113,193.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[26:0], 5'h13};
    endfunction

    // Instruction memory with a 1-cycle registered read.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check this cycle's outputs against the model, advance.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        reset          = rst;
        #1;
        if (since_flush < 2) check("bubble_after_flush", {31'd0, if_valid}, 32'd0);
        else if (since_flush == 2) check("refill_after_flush", {31'd0, if_valid}, 32'd1);
        if (stall_hold) begin
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, held_pc);
            check("stall_instr", if_instr, held_instr);
        end
        if (rst && if_valid && rdy) begin
            check("pop_pc", if_pc, exp_pc);
            check("pop_instr", if_instr, mem_word(exp_pc));
            check("pop_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        stall_hold = rst && !rv && if_valid && !rdy;
        held_pc    = if_pc;
        held_instr = if_instr;
        if (!rst) begin
            exp_pc      = RESET_PC;
            since_flush = 0;
        end else if (rv) begin
            exp_pc      = rpc & ~32'd3;
            since_flush = 0;
        end else if (since_flush < 3) begin
            since_flush++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pops_before;
        reset          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);

        // Reset state
        repeat (3) tick(1'b1, 1'b0, 32'd0, 1'b0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc_plus4", if_pc_plus4, 32'd4);
        check("rst_addr", imem_addr, RESET_PC);

        // Reset release: first word after two edges
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("first_lat_valid", {31'd0, if_valid}, 32'd0);
        check("first_lat_addr", imem_addr, 32'd4);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("first_valid", {31'd0, if_valid}, 32'd1);
        check("first_pc", if_pc, 32'd0);
        check("first_instr", if_instr, 32'h13);
        for (int k = 1; k <= 2; k++) begin
            tick(1'b1, 1'b0, 32'd0, 1'b1);
            check("stream_valid", {31'd0, if_valid}, 32'd1);
            check("stream_pc", if_pc, 32'(4 * k));
        end

        // Stall at pc 8 for 5 cycles
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 32'd0, 1'b1);
            check("stall_hold_pc", if_pc, 32'd8);
            check("stall_hold_instr", if_instr, 32'h113);
            check("stall_addr", imem_addr, 32'd16);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 32'd0, 1'b1);
            check("resume_valid", {31'd0, if_valid}, 32'd1);
            check("resume_pc", if_pc, 32'(12 + 4 * k));
        end

        // Redirect to 0x40 while stalled with buffered and in-flight words
        tick(1'b0, 1'b1, 32'h40, 1'b1);
        check("redir_valid0", {31'd0, if_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("redir_valid1", {31'd0, if_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("redir_valid2", {31'd0, if_valid}, 32'd1);
        check("redir_pc", if_pc, 32'h40);
        check("redir_instr", if_instr, mem_word(32'h40));

        // Unaligned redirect target, issued while a pop is happening
        tick(1'b1, 1'b1, 32'h43, 1'b1);
        check("align_addr", imem_addr, 32'h40);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("align_pc", if_pc, 32'h40);

        // PC wrap at the top of the address space
        tick(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("wrap_addr2", imem_addr, 32'd0);
        check("wrap_head0", if_pc, 32'hFFFF_FFF8);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("wrap_head1", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_pc_plus4, 32'd0);

        // Mid-stream reset with a full buffer
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        check("full_valid", {31'd0, if_valid}, 32'd1);
        tick(1'b0, 1'b0, 32'd0, 1'b0);
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_pc", if_pc, 32'd0);
        check("mid_rst_instr", if_instr, 32'd0);
        check("mid_rst_plus4", if_pc_plus4, 32'd4);
        check("mid_rst_addr", imem_addr, RESET_PC);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("restart_valid0", {31'd0, if_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        check("restart_pc", if_pc, RESET_PC);
        check("restart_instr", if_instr, mem_word(RESET_PC));

        // Randomized traffic: backpressure, redirects and occasional resets
        pops_before = n_pops;
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom,
                 ($urandom_range(0, 63) != 0));
        end
        check("random_progress", {31'd0, ((n_pops - pops_before) > 80)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
